// File: rtl/ptmch_trg_gen_if.sv
// -----------------------------------------------------------------------------
// ptmch_trg_gen_if
// SPI command bus between the external host and the trigger generator.
//   spi_cs   : chip select, active-low, asynchronous to the system clock
//   spi_clk  : SPI clock, mode 0 (MOSI valid on the rising edge)
//   spi_mosi : serial command data, MSB first
// Modports: master = host side (drives the bus), slave = trigger generator.
// -----------------------------------------------------------------------------
interface ptmch_trg_gen_if;
    logic spi_cs;
    logic spi_clk;
    logic spi_mosi;

    modport master (output spi_cs, output spi_clk, output spi_mosi);
    modport slave  (input  spi_cs, input  spi_clk, input  spi_mosi);
endinterface

// File: rtl/ptmch_trg_gen.sv
// -----------------------------------------------------------------------------
// ptmch_trg_gen
// SPI-programmed N_CH-channel trigger pulse generator.
// The SPI bus is oversampled in the clk200m domain. Frames of 8 + CNT_W bits
// ({op[2:0], ch[4:0], data[CNT_W-1:0]}) write per-channel DELAY / WIDTH /
// PERIOD / REPEAT registers or FIRE / STOP a set of channels. Each channel
// produces a one-shot pulse or a periodic pulse train.
// Ports:
//   clk200m  : system clock
//   reset_n  : asynchronous active-low reset
//   spi      : SPI command bus (slave modport)
//   trg_pls  : per-channel trigger pulses, registered
//   trg_busy : per-channel status, high while the channel is not idle
//   frm_err  : one-cycle pulse when a frame of the wrong length is discarded
// -----------------------------------------------------------------------------
module ptmch_trg_gen #(
    parameter int N_CH     = 3,
    parameter int CNT_W    = 16,
    parameter int SYNC_STG = 2
) (
    input  logic                clk200m,
    input  logic                reset_n,
    ptmch_trg_gen_if.slave      spi,
    output logic [N_CH-1:0]     trg_pls,
    output logic [N_CH-1:0]     trg_busy,
    output logic                frm_err
);

    localparam int FRAME_W = 8 + CNT_W;
    localparam int BCNT_W  = $clog2(FRAME_W + 2);

    localparam logic [BCNT_W-1:0] BCNT_FULL = BCNT_W'(FRAME_W);
    localparam logic [BCNT_W-1:0] BCNT_SAT  = BCNT_W'(FRAME_W + 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W:0]    PER_ONE   = {{CNT_W{1'b0}}, 1'b1};

    localparam logic [2:0] OP_FIRE = 3'b100;
    localparam logic [2:0] OP_STOP = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DLY,
        ST_PLS,
        ST_GAP
    } ch_state_t;

    // ------------------------------------------------------------------
    // SPI input synchronizers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STG-1:0] cs_sync_reg;
    logic [SYNC_STG-1:0] sclk_sync_reg;
    logic [SYNC_STG-1:0] mosi_sync_reg;
    logic                cs_prev_reg;
    logic                sclk_prev_reg;

    logic cs_s, sclk_s, mosi_s;
    logic cs_rise, cs_fall, sclk_rise;

    always_ff @(posedge clk200m or negedge reset_n) begin
        if (!reset_n) begin
            cs_sync_reg   <= '0;
            sclk_sync_reg <= '0;
            mosi_sync_reg <= '0;
            cs_prev_reg   <= 1'b0;
            sclk_prev_reg <= 1'b0;
        end else begin
            cs_sync_reg   <= {cs_sync_reg[SYNC_STG-2:0],   spi.spi_cs};
            sclk_sync_reg <= {sclk_sync_reg[SYNC_STG-2:0], spi.spi_clk};
            mosi_sync_reg <= {mosi_sync_reg[SYNC_STG-2:0], spi.spi_mosi};
            cs_prev_reg   <= cs_s;
            sclk_prev_reg <= sclk_s;
        end
    end

    assign cs_s      = cs_sync_reg[SYNC_STG-1];
    assign sclk_s    = sclk_sync_reg[SYNC_STG-1];
    assign mosi_s    = mosi_sync_reg[SYNC_STG-1];
    assign cs_rise   = cs_s & ~cs_prev_reg;
    assign cs_fall   = ~cs_s & cs_prev_reg;
    assign sclk_rise = sclk_s & ~sclk_prev_reg;

    // ------------------------------------------------------------------
    // Frame assembly. frame_act_reg is only set by an observed CS falling
    // edge, so a CS that was already low when reset released (or the
    // synchronizers settling to an idle-high CS) never produces a frame
    // or a frame error.
    // ------------------------------------------------------------------
    logic                frame_act_reg;
    logic [FRAME_W-1:0]  shift_reg;
    logic [BCNT_W-1:0]   bit_cnt_reg;
    logic                exec_reg;
    logic [2:0]          exec_op_reg;
    logic [4:0]          exec_ch_reg;
    logic [CNT_W-1:0]    exec_data_reg;
    logic                frm_err_reg;

    always_ff @(posedge clk200m or negedge reset_n) begin
        if (!reset_n) begin
            frame_act_reg <= 1'b0;
            shift_reg     <= '0;
            bit_cnt_reg   <= '0;
            exec_reg      <= 1'b0;
            exec_op_reg   <= '0;
            exec_ch_reg   <= '0;
            exec_data_reg <= '0;
            frm_err_reg   <= 1'b0;
        end else begin
            exec_reg    <= 1'b0;
            frm_err_reg <= 1'b0;
            if (cs_fall) begin
                frame_act_reg <= 1'b1;
                bit_cnt_reg   <= '0;
            end else if (cs_rise) begin
                frame_act_reg <= 1'b0;
                if (frame_act_reg) begin
                    if (bit_cnt_reg == BCNT_FULL) begin
                        exec_reg      <= 1'b1;
                        exec_op_reg   <= shift_reg[FRAME_W-1 -: 3];
                        exec_ch_reg   <= shift_reg[FRAME_W-4 -: 5];
                        exec_data_reg <= shift_reg[CNT_W-1:0];
                    end else begin
                        frm_err_reg <= 1'b1;
                    end
                end
            end else if (frame_act_reg && !cs_s && sclk_rise) begin
                shift_reg <= {shift_reg[FRAME_W-2:0], mosi_s};
                if (bit_cnt_reg != BCNT_SAT) begin
                    bit_cnt_reg <= bit_cnt_reg + 1'b1;
                end
            end
        end
    end

    assign frm_err = frm_err_reg;

    // ------------------------------------------------------------------
    // Trigger channels
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [CNT_W-1:0] delay_reg;
            logic [CNT_W-1:0] width_reg;
            logic [CNT_W-1:0] period_reg;
            logic             repeat_reg;

            ch_state_t        state_reg;
            logic [CNT_W-1:0] dly_cnt_reg;
            logic [CNT_W-1:0] wid_cnt_reg;
            logic [CNT_W:0]   per_cnt_reg;
            logic             pls_reg;
            logic             busy_reg;

            logic             mask_bit;
            logic             wr_hit;
            logic             fire_hit;
            logic             stop_hit;
            logic [CNT_W:0]   width_p1;
            logic [CNT_W:0]   per_eff;

            // FIRE/STOP select channels through the data field
            if (gi < CNT_W) begin : g_mask
                assign mask_bit = exec_data_reg[gi];
            end else begin : g_nomask
                assign mask_bit = 1'b0;
            end

            assign wr_hit   = exec_reg && (exec_ch_reg == 5'(gi));
            assign fire_hit = exec_reg && (exec_op_reg == OP_FIRE) && mask_bit;
            assign stop_hit = exec_reg && (exec_op_reg == OP_STOP) && mask_bit;

            // Rise-to-rise spacing, forced to leave at least one low cycle
            assign width_p1 = {1'b0, width_reg} + PER_ONE;
            assign per_eff  = ({1'b0, period_reg} > width_p1) ? {1'b0, period_reg} : width_p1;

            always_ff @(posedge clk200m or negedge reset_n) begin
                if (!reset_n) begin
                    delay_reg  <= '0;
                    width_reg  <= '0;
                    period_reg <= '0;
                    repeat_reg <= 1'b0;
                end else if (wr_hit) begin
                    case (exec_op_reg)
                        3'b000:  delay_reg  <= exec_data_reg;
                        3'b001:  width_reg  <= exec_data_reg;
                        3'b010:  period_reg <= exec_data_reg;
                        3'b011:  repeat_reg <= exec_data_reg[0];
                        default: ;
                    endcase
                end
            end

            // Working counters are loaded only on phase entry, so register
            // writes never disturb a phase already in progress. per_cnt_reg
            // runs through both PLS and GAP and measures rise-to-rise time.
            always_ff @(posedge clk200m or negedge reset_n) begin
                if (!reset_n) begin
                    state_reg   <= ST_IDLE;
                    dly_cnt_reg <= '0;
                    wid_cnt_reg <= '0;
                    per_cnt_reg <= '0;
                    pls_reg     <= 1'b0;
                    busy_reg    <= 1'b0;
                end else if (stop_hit && state_reg != ST_IDLE) begin
                    state_reg <= ST_IDLE;
                    pls_reg   <= 1'b0;
                    busy_reg  <= 1'b0;
                end else if (fire_hit) begin
                    if (delay_reg != '0) begin
                        state_reg   <= ST_DLY;
                        dly_cnt_reg <= delay_reg - CNT_ONE;
                        pls_reg     <= 1'b0;
                        busy_reg    <= 1'b1;
                    end else if (width_reg != '0) begin
                        state_reg   <= ST_PLS;
                        wid_cnt_reg <= width_reg - CNT_ONE;
                        per_cnt_reg <= per_eff - PER_ONE;
                        pls_reg     <= 1'b1;
                        busy_reg    <= 1'b1;
                    end else begin
                        state_reg <= ST_IDLE;
                        pls_reg   <= 1'b0;
                        busy_reg  <= 1'b0;
                    end
                end else begin
                    case (state_reg)
                        ST_DLY: begin
                            if (dly_cnt_reg != '0) begin
                                dly_cnt_reg <= dly_cnt_reg - CNT_ONE;
                            end else if (width_reg != '0) begin
                                state_reg   <= ST_PLS;
                                wid_cnt_reg <= width_reg - CNT_ONE;
                                per_cnt_reg <= per_eff - PER_ONE;
                                pls_reg     <= 1'b1;
                            end else begin
                                state_reg <= ST_IDLE;
                                busy_reg  <= 1'b0;
                            end
                        end
                        ST_PLS: begin
                            per_cnt_reg <= per_cnt_reg - PER_ONE;
                            if (wid_cnt_reg != '0) begin
                                wid_cnt_reg <= wid_cnt_reg - CNT_ONE;
                            end else begin
                                pls_reg <= 1'b0;
                                if (repeat_reg) begin
                                    state_reg <= ST_GAP;
                                end else begin
                                    state_reg <= ST_IDLE;
                                    busy_reg  <= 1'b0;
                                end
                            end
                        end
                        ST_GAP: begin
                            if (per_cnt_reg != '0) begin
                                per_cnt_reg <= per_cnt_reg - PER_ONE;
                            end else if (width_reg != '0) begin
                                state_reg   <= ST_PLS;
                                wid_cnt_reg <= width_reg - CNT_ONE;
                                per_cnt_reg <= per_eff - PER_ONE;
                                pls_reg     <= 1'b1;
                            end else begin
                                state_reg <= ST_IDLE;
                                busy_reg  <= 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            assign trg_pls[gi]  = pls_reg;
            assign trg_busy[gi] = busy_reg;
        end
    endgenerate

endmodule

// File: tb/tb_ptmch_trg_gen.sv
// -----------------------------------------------------------------------------
// tb_ptmch_trg_gen
// Drives SPI frames into ptmch_trg_gen (directed scenarios followed by random
// frames) and compares trg_pls / trg_busy / frm_err every cycle against an
// event-time model: each channel is described by its next rise time and the
// last high cycle of the current pulse, derived from DELAY/WIDTH/PERIOD.
// -----------------------------------------------------------------------------
module tb_ptmch_trg_gen;

    localparam int N_CH     = 3;
    localparam int CNT_W    = 16;
    localparam int SYNC_STG = 2;
    localparam int FRAME_W  = 8 + CNT_W;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [N_CH-1:0] trg_pls;
    logic [N_CH-1:0] trg_busy;
    logic            frm_err;

    ptmch_trg_gen_if spi_bus ();

    ptmch_trg_gen #(
        .N_CH     (N_CH),
        .CNT_W    (CNT_W),
        .SYNC_STG (SYNC_STG)
    ) dut (
        .clk200m  (clk),
        .reset_n  (reset_n),
        .spi      (spi_bus),
        .trg_pls  (trg_pls),
        .trg_busy (trg_busy),
        .frm_err  (frm_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        int       due;
        bit       err;
        bit [2:0] op;
        bit [4:0] ch;
        int       data;
    } ev_t;

    ev_t pend[$];

    int m_delay [N_CH];
    int m_width [N_CH];
    int m_period[N_CH];
    bit m_rep   [N_CH];
    bit act     [N_CH];
    bit wt      [N_CH];
    int nrise   [N_CH];
    int hend    [N_CH];

    logic [N_CH-1:0] exp_pls;
    logic [N_CH-1:0] exp_busy;
    logic            exp_err;

    task automatic model_reset();
        pend.delete();
        for (int i = 0; i < N_CH; i++) begin
            m_delay[i] = 0; m_width[i] = 0; m_period[i] = 0; m_rep[i] = 0;
            act[i] = 0; wt[i] = 0; nrise[i] = 0; hend[i] = 0;
        end
        exp_pls = '0; exp_busy = '0; exp_err = 1'b0;
    endtask

    // Computes the expected outputs for cycle t. Registers seen here are
    // the values of cycle t-1; a write arriving now is applied afterwards.
    task automatic model_step(input int t);
        ev_t      e;
        bit       cmd_v;
        bit [2:0] op;
        bit [4:0] ch;
        int       data;
        cmd_v = 0; op = 0; ch = 0; data = 0; exp_err = 1'b0;
        while (pend.size() != 0 && pend[0].due <= t) begin
            e = pend.pop_front();
            if (e.err) exp_err = 1'b1;
            else begin cmd_v = 1; op = e.op; ch = e.ch; data = e.data; end
        end
        for (int i = 0; i < N_CH; i++) begin
            bit hit;
            hit = cmd_v && data[i];
            if (hit && op == 3'd5) begin
                act[i] = 0; wt[i] = 0;
            end else if (hit && op == 3'd4) begin
                act[i] = 1; wt[i] = 1; nrise[i] = t + m_delay[i];
            end else if (act[i] && !wt[i] && t == hend[i] + 1) begin
                if (m_rep[i]) wt[i] = 1;
                else act[i] = 0;
            end
            if (act[i] && wt[i] && t == nrise[i]) begin
                wt[i] = 0;
                if (m_width[i] == 0) act[i] = 0;
                else begin
                    hend[i]  = t + m_width[i] - 1;
                    nrise[i] = t + ((m_period[i] > m_width[i]) ? m_period[i] : m_width[i] + 1);
                end
            end
            exp_pls[i]  = act[i] && !wt[i];
            exp_busy[i] = act[i];
        end
        if (cmd_v && op <= 3'd3 && int'(ch) < N_CH) begin
            case (op)
                3'd0: m_delay[ch]  = data;
                3'd1: m_width[ch]  = data;
                3'd2: m_period[ch] = data;
                default: m_rep[ch] = data[0];
            endcase
        end
    endtask

    // Per-cycle monitor
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (!reset_n) model_reset();
            else begin
                model_step(cyc);
                check_val("trg_pls",  32'(trg_pls),  32'(exp_pls));
                check_val("trg_busy", 32'(trg_busy), 32'(exp_busy));
                check_val("frm_err",  32'(frm_err),  32'(exp_err));
            end
        end
    end

    // ------------------------------------------------------------------
    // SPI host driver
    // ------------------------------------------------------------------
    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input bit [2:0] op, input bit [4:0] ch, input int data, input int nbits);
        logic [FRAME_W-1:0] word;
        ev_t e;
        int  hp;
        word = {op, ch, data[CNT_W-1:0]};
        hp   = $urandom_range(4, 6);
        @(negedge clk);
        spi_bus.spi_cs = 1'b0;
        wait_cycles(4);
        for (int i = 0; i < nbits; i++) begin
            spi_bus.spi_mosi = (i < FRAME_W) ? word[FRAME_W-1-i] : 1'b0;
            wait_cycles(hp);
            spi_bus.spi_clk = 1'b1;
            wait_cycles(hp);
            spi_bus.spi_clk = 1'b0;
        end
        wait_cycles(4);
        spi_bus.spi_cs = 1'b1;
        // CS rise crosses SYNC_STG flops, is detected the cycle after, and
        // becomes the exec strobe (cycle T) / FRM_ERR pulse one edge later;
        // channel outputs for T+1 appear on the following edge.
        e.err  = (nbits != FRAME_W);
        e.due  = e.err ? cyc + SYNC_STG + 1 : cyc + SYNC_STG + 2;
        e.op   = op;
        e.ch   = ch;
        e.data = data;
        pend.push_back(e);
        $display("frame op=%0d ch=%0d data=%0h bits=%0d cs_rise_cyc=%0d", op, ch, data, nbits, cyc);
        wait_cycles(SYNC_STG + 4);
    endtask

    task automatic wr(input bit [2:0] op, input bit [4:0] ch, input int data);
        send_frame(op, ch, data, FRAME_W);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        spi_bus.spi_cs   = 1'b1;
        spi_bus.spi_clk  = 1'b0;
        spi_bus.spi_mosi = 1'b0;
        wait_cycles(3);
        check_val("rst_pls",  32'(trg_pls),  32'd0);
        check_val("rst_busy", 32'(trg_busy), 32'd0);
        check_val("rst_err",  32'(frm_err),  32'd0);
        reset_n = 1'b1;
        wait_cycles(10);

        // one-shot with delay on ch1
        wr(3'd0, 5'd1, 10); wr(3'd1, 5'd1, 5); wr(3'd3, 5'd1, 0);
        wr(3'd4, 5'd0, 'h2); wait_cycles(40);

        // periodic train on ch0, then STOP
        wr(3'd0, 5'd0, 0); wr(3'd1, 5'd0, 3); wr(3'd2, 5'd0, 8); wr(3'd3, 5'd0, 1);
        wr(3'd4, 5'd0, 'h1); wait_cycles(20);
        wr(3'd5, 5'd0, 'h1); wait_cycles(20);

        // period shorter than width on ch2
        wr(3'd1, 5'd2, 6); wr(3'd2, 5'd2, 4); wr(3'd3, 5'd2, 1);
        wr(3'd4, 5'd0, 'h4); wait_cycles(30);
        wr(3'd5, 5'd0, 'h4); wait_cycles(10);

        // bad-length frames, out-of-range channel, no-op opcodes
        send_frame(3'd0, 5'd0, 77, FRAME_W - 1);
        send_frame(3'd1, 5'd0, 77, FRAME_W + 1);
        send_frame(3'd0, 5'd1, 77, 0);
        wr(3'd0, 5'd5, 9); wr(3'd6, 5'd0, 'h7); wr(3'd7, 5'd1, 'h7);
        wr(3'd4, 5'd0, 'h3); wait_cycles(30);
        wr(3'd5, 5'd0, 'h3); wait_cycles(10);

        // retrigger ch0 while its pulse is high
        wr(3'd0, 5'd0, 4); wr(3'd1, 5'd0, 300); wr(3'd3, 5'd0, 0);
        wr(3'd4, 5'd0, 'h1); wr(3'd4, 5'd0, 'h1); wait_cycles(320);

        // WIDTH written during GAP applies to the next pulse only
        wr(3'd0, 5'd0, 0); wr(3'd1, 5'd0, 3); wr(3'd2, 5'd0, 250); wr(3'd3, 5'd0, 1);
        wr(3'd4, 5'd0, 'h1); wait_cycles(10);
        wr(3'd1, 5'd0, 6); wait_cycles(300);
        // clearing REPEAT ends the train after the current pulse
        wr(3'd3, 5'd0, 0); wait_cycles(300);

        // reset in the middle of a pulse
        wr(3'd0, 5'd1, 0); wr(3'd1, 5'd1, 200);
        wr(3'd4, 5'd0, 'h2); wait_cycles(20);
        #1 reset_n = 1'b0;
        #1;
        check_val("rst_mid_pls",  32'(trg_pls),  32'd0);
        check_val("rst_mid_busy", 32'(trg_busy), 32'd0);
        wait_cycles(3);
        reset_n = 1'b1;
        wr(3'd4, 5'd0, 'h7); wait_cycles(20);

        // random frames
        for (int k = 0; k < 40; k++) begin
            int       r;
            int       d;
            int       nb;
            bit [2:0] op;
            bit [4:0] ch;
            r  = $urandom_range(0, 9);
            ch = 5'($urandom_range(0, 4));
            nb = FRAME_W;
            d  = 0;
            if (r <= 3) begin
                op = 3'($urandom_range(0, 2)); d = $urandom_range(0, 20);
            end else if (r == 4) begin
                op = 3'd3; d = $urandom_range(0, 1);
            end else if (r <= 6) begin
                op = 3'd4; d = $urandom_range(1, 15);
            end else if (r == 7) begin
                op = 3'd5; d = $urandom_range(0, 15);
            end else if (r == 8) begin
                op = 3'($urandom_range(6, 7)); d = $urandom_range(0, 15);
            end else begin
                op = 3'($urandom_range(0, 7)); d = $urandom_range(0, 15);
                case ($urandom_range(0, 3))
                    0:       nb = FRAME_W - 1;
                    1:       nb = FRAME_W + 1;
                    2:       nb = FRAME_W + 5;
                    default: nb = 0;
                endcase
            end
            send_frame(op, ch, d, nb);
            wait_cycles($urandom_range(0, 40));
        end
        wait_cycles(100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Run-length bound
    initial begin
        #800000;
        check_val("watchdog", 32'd1, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
